// File: rtl/noc_mem_endpoint_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noc_mem_endpoint_pkg : packet format, type codes and payload field offsets
// Revision: 1.0
// ----------------------------------------------------------------------------
package noc_mem_endpoint_pkg;

  localparam int NOC_ADDR_W = 8;
  localparam int NOC_PORT_W = 4;
  localparam int NOC_DAT_W  = 184;
  localparam int LINE_W     = 128;
  localparam int LINE_BYTES = 16;

  typedef struct packed {
    logic [NOC_ADDR_W-1:0] dst_addr;
    logic [NOC_PORT_W-1:0] dst_port;
    logic [NOC_ADDR_W-1:0] src_addr;
    logic [NOC_PORT_W-1:0] src_port;
  } noc_header;

  typedef struct packed {
    noc_header             hdr;
    logic [NOC_DAT_W-1:0]  dat;
  } noc_packet;

  localparam logic [7:0] memory_read_request  = 8'h10;
  localparam logic [7:0] memory_read_reply    = 8'h11;
  localparam logic [7:0] memory_write_request = 8'h12;
  localparam logic [7:0] memory_write_reply   = 8'h13;

  localparam int OFS_TYPE  = 0;
  localparam int OFS_ADDR  = 8;
  localparam int OFS_WDATA = 40;
  localparam int OFS_WMSK  = 168;
  localparam int OFS_RDATA = 8;
  localparam int OFS_RADDR = 136;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_REPLY  = 2'd2
  } state_e;

  function automatic logic [7:0] pkt_type(input noc_packet p);
    return p.dat[OFS_TYPE +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_mem_endpoint_mem_line_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_line_array : single-port line memory, byte write mask, registered read
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_line_array
  import noc_mem_endpoint_pkg::*;
#(
  parameter int unsigned MEM_LINES = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [LINE_W-1:0]     wdata,
  input  logic [LINE_BYTES-1:0] wmsk,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem_q [MEM_LINES];
  logic [LINE_W-1:0] rdata_q;

  // rdata_q only moves on a read, so it doubles as the stable reply buffer
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
          if (wmsk[b]) begin
            mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/noc_mem_endpoint.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noc_mem_endpoint : NOC memory target, serialised line read / masked write
// Revision: 1.0
// ----------------------------------------------------------------------------
module noc_mem_endpoint
  import noc_mem_endpoint_pkg::*;
#(
  parameter int unsigned MEM_LINES = 256,
  parameter int unsigned ACC_LAT   = 4,
  parameter int unsigned NODE_ADDR = 0,
  parameter int unsigned NODE_PORT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_av,
  output logic       rx_re,
  input  noc_packet  rx_dat,
  output logic       tx_av,
  input  logic       tx_re,
  output noc_packet  tx_dat,
  output logic [7:0] drop_cnt
);

  localparam int unsigned IDX_W = $clog2(MEM_LINES);
  localparam int unsigned LAT_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [7:0]            drop_q, drop_d;

  logic                  req_wr_q;
  noc_header             req_hdr_q;
  logic [31:0]           req_addr_q;
  logic [LINE_W-1:0]     req_wdata_q;
  logic [LINE_BYTES-1:0] req_wmsk_q;

  logic                  rx_is_rd, rx_is_wr, accept_req, mem_en;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  unused_dst;

  assign rx_is_rd   = (pkt_type(rx_dat) == memory_read_request);
  assign rx_is_wr   = (pkt_type(rx_dat) == memory_write_request);
  assign unused_dst = ^{rx_dat.hdr.dst_addr, rx_dat.hdr.dst_port};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr_q    <= 1'b0;
      req_hdr_q   <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmsk_q  <= '0;
    end else if (accept_req) begin
      req_wr_q    <= rx_is_wr;
      req_hdr_q   <= rx_dat.hdr;
      req_addr_q  <= rx_dat.dat[OFS_ADDR +: 32];
      req_wdata_q <= rx_dat.dat[OFS_WDATA +: LINE_W];
      req_wmsk_q  <= rx_dat.dat[OFS_WMSK +: LINE_BYTES];
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    drop_d     = drop_q;
    rx_re      = 1'b0;
    tx_av      = 1'b0;
    accept_req = 1'b0;
    mem_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rx_re = 1'b1;
        if (rx_av) begin
          if (rx_is_rd || rx_is_wr) begin
            accept_req = 1'b1;
            lat_d      = LAT_W'(ACC_LAT - 1);
            state_d    = ST_ACCESS;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      ST_ACCESS: begin
        if (lat_q == '0) begin
          mem_en  = 1'b1;
          state_d = ST_REPLY;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_REPLY: begin
        tx_av = 1'b1;
        if (tx_re) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reply is a pure function of state and latched request, so it holds under back-pressure
  always_comb begin
    tx_dat = '0;
    if (state_q == ST_REPLY) begin
      tx_dat.hdr.dst_addr = req_hdr_q.src_addr;
      tx_dat.hdr.dst_port = req_hdr_q.src_port;
      tx_dat.hdr.src_addr = NOC_ADDR_W'(NODE_ADDR);
      tx_dat.hdr.src_port = NOC_PORT_W'(NODE_PORT);
      if (req_wr_q) begin
        tx_dat.dat[OFS_TYPE +: 8]  = memory_write_reply;
        tx_dat.dat[OFS_ADDR +: 32] = req_addr_q;
      end else begin
        tx_dat.dat[OFS_TYPE +: 8]       = memory_read_reply;
        tx_dat.dat[OFS_RDATA +: LINE_W] = mem_rdata;
        tx_dat.dat[OFS_RADDR +: 32]     = req_addr_q;
      end
    end
  end

  assign drop_cnt = drop_q;

  mem_line_array #(
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (req_wr_q),
    .idx   (req_addr_q[4 +: IDX_W]),
    .wdata (req_wdata_q),
    .wmsk  (req_wmsk_q),
    .rdata (mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_noc_mem_endpoint.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_noc_mem_endpoint : directed bench with a byte-level memory/reply model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_noc_mem_endpoint;
  import noc_mem_endpoint_pkg::*;

  localparam int unsigned MEM_LINES = 256;
  localparam int unsigned ACC_LAT   = 4;
  localparam int unsigned NODE_ADDR = 8'h5A;
  localparam int unsigned NODE_PORT = 4'h2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_av;
  logic       rx_re;
  noc_packet  rx_dat;
  logic       tx_av;
  logic       tx_re;
  noc_packet  tx_dat;
  logic [7:0] drop_cnt;

  noc_mem_endpoint #(
    .MEM_LINES (MEM_LINES),
    .ACC_LAT   (ACC_LAT),
    .NODE_ADDR (NODE_ADDR),
    .NODE_PORT (NODE_PORT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_av    (rx_av),
    .rx_re    (rx_re),
    .rx_dat   (rx_dat),
    .tx_av    (tx_av),
    .tx_re    (tx_re),
    .tx_dat   (tx_dat),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs after the next rising edge
  logic       exp_rx_re = 1'b1;
  logic       exp_tx_av = 1'b0;
  logic [7:0] exp_drop  = 8'd0;
  noc_packet  exp_pkt   = '0;

  logic [7:0] mem_m [MEM_LINES][LINE_BYTES];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("rx_re", 256'(rx_re), 256'(exp_rx_re));
    chk("tx_av", 256'(tx_av), 256'(exp_tx_av));
    chk("drop_cnt", 256'(drop_cnt), 256'(exp_drop));
    if (exp_tx_av) chk("tx_dat", 256'(tx_dat), 256'(exp_pkt));
  end

  function automatic noc_packet mk_rd(input logic [31:0] a, input logic [7:0] sa, input logic [3:0] sp);
    noc_packet p;
    p = '0;
    p.hdr.src_addr = sa;
    p.hdr.src_port = sp;
    p.hdr.dst_addr = 8'hA5;
    p.dat[7:0]     = memory_read_request;
    p.dat[8 +: 32] = a;
    return p;
  endfunction

  function automatic noc_packet mk_wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m,
                                      input logic [7:0] sa, input logic [3:0] sp);
    noc_packet p;
    p = mk_rd(a, sa, sp);
    p.dat[7:0]       = memory_write_request;
    p.dat[40 +: 128] = d;
    p.dat[168 +: 16] = m;
    return p;
  endfunction

  function automatic noc_packet mk_raw(input logic [7:0] t);
    noc_packet p;
    p = '0;
    p.dat[7:0] = t;
    p.dat[8 +: 32] = 32'h20;
    return p;
  endfunction

  // Applies a request to the byte model and returns the reply it must produce
  function automatic noc_packet model_req(input noc_packet p);
    noc_packet   r;
    logic [31:0] a;
    int unsigned ln;
    r  = '0;
    a  = p.dat[8 +: 32];
    ln = (a / 16) % MEM_LINES;
    r.hdr.dst_addr = p.hdr.src_addr;
    r.hdr.dst_port = p.hdr.src_port;
    r.hdr.src_addr = 8'(NODE_ADDR);
    r.hdr.src_port = 4'(NODE_PORT);
    if (p.dat[7:0] == memory_read_request) begin
      r.dat[7:0] = memory_read_reply;
      for (int b = 0; b < 16; b++) r.dat[8 + 8*b +: 8] = mem_m[ln][b];
      r.dat[136 +: 32] = a;
    end else begin
      for (int b = 0; b < 16; b++)
        if (p.dat[168 + b]) mem_m[ln][b] = p.dat[40 + 8*b +: 8];
      r.dat[7:0]     = memory_write_reply;
      r.dat[8 +: 32] = a;
    end
    return r;
  endfunction

  // Called at a negedge with the block idle; returns the reply seen on tx_dat
  task automatic transact(input noc_packet p, input int bp, input bit junk, output noc_packet got);
    exp_pkt   = model_req(p);
    rx_av     = 1'b1;
    rx_dat    = p;
    exp_rx_re = 1'b0;
    exp_tx_av = 1'b0;
    @(negedge clk);
    rx_av  = junk;
    rx_dat = mk_raw(8'h7F);
    for (int i = 1; i < int'(ACC_LAT); i++) @(negedge clk);
    exp_tx_av = 1'b1;
    @(negedge clk);
    got = tx_dat;
    repeat (bp) @(negedge clk);
    tx_re     = 1'b1;
    rx_av     = 1'b0;
    exp_tx_av = 1'b0;
    exp_rx_re = 1'b1;
    @(negedge clk);
    tx_re = 1'b0;
  endtask

  localparam logic [127:0] D0   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] DMSK = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_CCDDEEFF;

  initial begin
    noc_packet got;
    logic [127:0] rnd;
    rst    = 1'b0;
    rx_av  = 1'b0;
    tx_re  = 1'b0;
    rx_dat = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx_dat", 256'(tx_dat), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    transact(mk_wr(32'h20, D0, 16'hFFFF, 8'd3, 4'd1), 0, 1'b0, got);
    chk("wr_rep_type", 256'(got.dat[7:0]), 256'(memory_write_reply));
    chk("wr_rep_dst", 256'({got.hdr.dst_addr, got.hdr.dst_port}), 256'(12'h031));
    chk("wr_rep_addr", 256'(got.dat[8 +: 32]), 256'(32'h20));

    transact(mk_rd(32'h20, 8'd3, 4'd1), 0, 1'b1, got);
    chk("rd_data", 256'(got.dat[8 +: 128]), 256'(D0));
    chk("rd_addr", 256'(got.dat[136 +: 32]), 256'(32'h20));

    transact(mk_wr(32'h20, {128{1'b1}}, 16'hFFF0, 8'd4, 4'd2), 0, 1'b0, got);
    transact(mk_rd(32'h20, 8'd4, 4'd2), 10, 1'b0, got);
    chk("mask_rd_data", 256'(got.dat[8 +: 128]), 256'(DMSK));

    rx_av  = 1'b1;
    rx_dat = mk_raw(8'h7F);
    exp_drop = 8'd1;
    @(negedge clk);
    rx_av = 1'b0;
    @(negedge clk);
    rx_av = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_drop = (exp_drop == 8'd255) ? 8'd255 : exp_drop + 8'd1;
      @(negedge clk);
    end
    rx_av = 1'b0;
    @(negedge clk);
    chk("drop_sat", 256'(drop_cnt), 256'(255));

    transact(mk_rd(MEM_LINES * 16 + 32'h20, 8'd7, 4'd3), 0, 1'b0, got);
    chk("wrap_data", 256'(got.dat[8 +: 128]), 256'(DMSK));
    chk("wrap_addr", 256'(got.dat[136 +: 32]), 256'(32'h1020));

    // Write interrupted by reset must not reach the model or the array
    rx_av     = 1'b1;
    rx_dat    = mk_wr(32'h20, 128'h0, 16'hFFFF, 8'd1, 4'd1);
    exp_rx_re = 1'b0;
    @(negedge clk);
    rx_av = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    exp_rx_re = 1'b1;
    exp_drop  = 8'd0;
    #1;
    chk("rst_tx_av", 256'(tx_av), 256'(0));
    chk("rst_rx_re", 256'(rx_re), 256'(1));
    chk("rst_drop", 256'(drop_cnt), 256'(0));
    chk("rst_tx_dat", 256'(tx_dat), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    transact(mk_rd(32'h20, 8'd9, 4'd4), 0, 1'b0, got);
    chk("post_rst_data", 256'(got.dat[8 +: 128]), 256'(DMSK));

    rnd = {$urandom, $urandom, $urandom, $urandom};
    transact(mk_wr(32'h1234_5670, rnd, 16'hFFFF, 8'd2, 4'd5), 3, 1'b0, got);
    transact(mk_rd(32'h0000_0670, 8'd2, 4'd5), 0, 1'b0, got);
    chk("idx_data", 256'(got.dat[8 +: 128]), 256'(rnd));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_mem_endpoint.md
# noc_mem_endpoint

NOC-attached main-memory target that sits directly downstream of the core memory access controller across the NOC. It accepts one request packet at a time, either a line read or a masked line write. It performs the access on a local 16-byte-line memory after a fixed latency and returns a reply packet addressed back to the requester. Requests are strictly serialised, so read-after-write ordering is exact.

## Interface
Parameters:
- MEM_LINES, 256: number of 16-byte lines; power of two.
- ACC_LAT, 4: access latency in cycles; must be ≥1.
- NODE_ADDR, 0: own NOC address, placed in reply src_addr.
- NODE_PORT, 0: own NOC port, placed in reply src_port.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rx_av  in  1  NOC has a packet for this block.
- rx_re  out  1  block accepts rx_dat this cycle.
- rx_dat  in  noc_packet  incoming request packet.
- tx_av  out  1  block has a reply packet.
- tx_re  in  1  NOC accepts tx_dat this cycle.
- tx_dat  out  noc_packet  outgoing reply packet.
- drop_cnt  out  8  count of dropped packets, saturating.

## Operation
- Payload dat[7:0] carries the packet type.
- memory_read_request: addr is dat[8+:32].
- memory_write_request: addr is dat[8+:32], data is dat[40+:128], wmsk is dat[168+:16].
- Line index is addr[4 +: log2(MEM_LINES)]. addr[3:0] and upper bits are ignored, so access is line-aligned and wraps modulo the memory size.
- wmsk bit i enables the write of byte i (data[8i+:8]).
- FSM states: IDLE, ACCESS, REPLY.
- IDLE: rx_re=1.
  - On rx_av && rx_re with a read or write type: latch the packet, load lat_cnt=ACC_LAT-1, go to ACCESS.
  - Any other type: consume the packet, drop_cnt+1 (saturates at 255), stay in IDLE, no reply.
- ACCESS: when lat_cnt==0, perform the access at that edge and go to REPLY; otherwise decrement lat_cnt.
  - Read: capture the line into the reply buffer.
  - Write: apply the masked write.
- REPLY: tx_av=1. On tx_re, go to IDLE.
- Reply header:
  - dst_addr/dst_port = request src_addr/src_port.
  - src_addr/src_port = NODE_ADDR/NODE_PORT.
- Read reply payload:
  - dat[7:0]=memory_read_reply.
  - dat[8+:128] = line data, byte i at [8+8i+:8].
  - dat[136+:32] = request addr, unmodified.
- Write reply payload:
  - dat[7:0]=memory_write_reply.
  - dat[8+:32] = request addr.
- Unused payload bits are 0.

## Timing
- Reset values: state=IDLE, rx_re=1, tx_av=0, tx_dat=0, drop_cnt=0, lat_cnt=0. Memory array is not reset.
- rx_re and tx_av are decoded from state only; there is no combinational path from rx_av or tx_re.
- Latency: a request accepted at edge E0 produces tx_av high after edge E0+ACC_LAT.
- tx_dat is held stable while tx_av=1 and until the handshake edge. tx_av may stay high indefinitely under back-pressure.
- rx_re returns high in the cycle after the reply handshake edge. Minimum request spacing is ACC_LAT+2 cycles.
- rx_re=0 in ACCESS and REPLY; rx_av is ignored there.
- Reset asserted mid-operation: outputs clear immediately and the in-flight request is lost with no reply. Memory writes already performed persist.
- Back-to-back access to the same line: the second request observes the first write, because requests are serialised.

## Structure
- Shared package (defines.svh) holds:
  - noc_packet and its header typedef.
  - Packet-type constants memory_read_request and memory_read_reply, plus new memory_write_request and memory_write_reply.
  - Payload field offsets.
- Sub-module mem_line_array: single-port MEM_LINES×128-bit array with a 16-bit byte write mask and registered read. It has no reset.
- Top level holds the FSM, lat_cnt, request latch, reply formatter and drop counter.

## Test plan
- Reset: assert rst=0 for 3 cycles -> rx_re=1, tx_av=0, drop_cnt=0; after release, rx_re=1.
- Write then read:
  - Stimulus: write to addr 0x20 with data 0x00112233445566778899AABBCCDDEEFF, wmsk 0xFFFF, src 3/1; then read 0x20.
  - Write -> write reply with dst 3/1 and addr 0x20.
  - Read -> tx_av rises ACC_LAT edges after acceptance; reply carries the same data and dat[136+:32]=0x20.
- Masked write: write 0xFF…FF with wmsk 0xFFF0 to line 0x20, then read -> bytes 0–3 keep 0xFF,0xEE,0xDD,0xCC; bytes 4–15 read 0xFF.
- Back-pressure: hold tx_re=0 for 10 cycles during a read reply -> tx_av stays 1, tx_dat is unchanged, rx_re=0; accepted on the first tx_re=1.
- Unknown type 0x7F -> consumed in one cycle, no tx_av. 300 such packets -> drop_cnt=255.
- Wrap and reset:
  - Read addr MEM_LINES*16+0x20 -> returns line 0x20, with the full original address echoed.
  - rst=0 during ACCESS -> tx_av=0 immediately, no reply; a subsequent read of 0x20 returns the pre-reset contents.
